// File: rtl/reg_wb_arbiter_pkg.sv
// Shared definitions for the register-file write-back arbiter.
// The package holds the source index map, the number of sources, the
// arbiter FSM state encoding and the default data/address widths.
package reg_wb_arbiter_pkg;

   localparam int NUM_SRC = 5;

   // Bit positions of each producer in the req/gnt vectors.
   localparam int SRC_ALU = 0;
   localparam int SRC_MOV = 1;
   localparam int SRC_L   = 2;
   localparam int SRC_TR  = 3;
   localparam int SRC_FIB = 4;

   localparam int DEFAULT_DW = 16;
   localparam int DEFAULT_AW = 3;

   typedef enum logic {
      IDLE = 1'b0,
      LOCK = 1'b1
   } wb_state_e;

endpackage

// File: rtl/reg_wb_arbiter_prio_pick.sv
// Combinational fixed-priority one-hot picker.
// Ports:
//   vec_i  - request vector, bit 0 has the highest priority
//   pick_o - one-hot copy of the lowest set bit of vec_i, zero if vec_i is zero
module prio_pick
   import reg_wb_arbiter_pkg::*;
(
   input  logic [NUM_SRC-1:0] vec_i,
   output logic [NUM_SRC-1:0] pick_o
);

   // Two's-complement trick: vec & -vec isolates the lowest set bit.
   assign pick_o = vec_i & (~vec_i + NUM_SRC'(1));

endmodule

// File: rtl/reg_wb_arbiter.sv
// Write-back scheduler for the single register-file write port.
// Five producers (ALU, MOV, load, TR, FIB) are arbitrated with fixed
// priority, starvation ageing and a FIB burst lock; the winner's address
// and data are registered onto the write port one cycle after the grant.
// Ports:
//   clk, rst             - clock, synchronous active-high reset
//   req                  - request per source (bit0 ALU .. bit4 FIB)
//   addr_*/data_*        - destination register and write data per source
//   fib_burst            - FIB asks for a burst lock (used when FIB is granted)
//   gnt                  - combinational one-hot grant
//   wr_en/wr_addr/wr_data- registered register-file write port
//   locked               - high while the FIB burst lock is held
module reg_wb_arbiter
   import reg_wb_arbiter_pkg::*;
#(
   parameter int DW         = DEFAULT_DW,
   parameter int AW         = DEFAULT_AW,
   parameter int STARVE_LIM = 4,
   parameter int LOCK_MAX   = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_SRC-1:0] req,
   input  logic [AW-1:0]      addr_alu,
   input  logic [AW-1:0]      addr_mov,
   input  logic [AW-1:0]      addr_l,
   input  logic [AW-1:0]      addr_tr,
   input  logic [AW-1:0]      addr_fib,
   input  logic [DW-1:0]      data_alu,
   input  logic [DW-1:0]      data_mov,
   input  logic [DW-1:0]      data_l,
   input  logic [DW-1:0]      data_tr,
   input  logic [DW-1:0]      data_fib,
   input  logic               fib_burst,
   output logic [NUM_SRC-1:0] gnt,
   output logic               wr_en,
   output logic [AW-1:0]      wr_addr,
   output logic [DW-1:0]      wr_data,
   output logic               locked
);

   logic [AW-1:0] addr_arr [NUM_SRC];
   logic [DW-1:0] data_arr [NUM_SRC];

   assign addr_arr[SRC_ALU] = addr_alu;
   assign addr_arr[SRC_MOV] = addr_mov;
   assign addr_arr[SRC_L]   = addr_l;
   assign addr_arr[SRC_TR]  = addr_tr;
   assign addr_arr[SRC_FIB] = addr_fib;
   assign data_arr[SRC_ALU] = data_alu;
   assign data_arr[SRC_MOV] = data_mov;
   assign data_arr[SRC_L]   = data_l;
   assign data_arr[SRC_TR]  = data_tr;
   assign data_arr[SRC_FIB] = data_fib;

   wb_state_e            state_q, state_d;
   logic [7:0]           cnt_q, cnt_d;
   logic [7:0]           cnt_inc;
   // Set after a LOCK_MAX exit: FIB may not re-lock while other sources
   // are still waiting, until one of them has been served.
   logic                 block_q, block_d;
   logic [NUM_SRC-1:0]   starved;
   logic [NUM_SRC-1:0]   starved_pick;
   logic [NUM_SRC-1:0]   full_pick;
   logic [NUM_SRC-1:0]   norm_gnt;
   logic                 others_pending;

   // Starvation age counters. starved[] is masked with req so a source
   // that has just dropped its request can never be granted.
   for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_age
      logic [3:0] age_q, age_d;

      always_comb begin
         age_d = 4'd0;
         if (req[gi] && !gnt[gi]) begin
            age_d = (age_q == 4'(STARVE_LIM)) ? age_q : age_q + 4'd1;
         end
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            age_q <= 4'd0;
         end else begin
            age_q <= age_d;
         end
      end

      assign starved[gi] = req[gi] && (age_q == 4'(STARVE_LIM));
   end

   prio_pick u_pick_starved (
      .vec_i  (starved),
      .pick_o (starved_pick)
   );

   prio_pick u_pick_full (
      .vec_i  (req),
      .pick_o (full_pick)
   );

   assign norm_gnt       = (|starved) ? starved_pick : full_pick;
   assign others_pending = |req[SRC_TR:SRC_ALU];
   assign cnt_inc        = cnt_q + 8'd1;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      block_d = block_q;
      gnt     = '0;

      case (state_q)
         IDLE: begin
            gnt = norm_gnt;
            if (gnt[SRC_FIB] && fib_burst && (!block_q || !others_pending)) begin
               if (LOCK_MAX > 1) begin
                  state_d = LOCK;
                  cnt_d   = 8'd1;
                  block_d = 1'b0;
               end else begin
                  // The entry write alone already exhausts the burst.
                  block_d = 1'b1;
               end
            end
         end
         LOCK: begin
            if (req[SRC_FIB]) begin
               gnt          = '0;
               gnt[SRC_FIB] = 1'b1;
               cnt_d        = cnt_inc;
               if (cnt_inc == 8'(LOCK_MAX)) begin
                  state_d = IDLE;
                  cnt_d   = 8'd0;
                  block_d = 1'b1;
               end else if (!fib_burst) begin
                  state_d = IDLE;
                  cnt_d   = 8'd0;
               end
            end else begin
               // FIB walked away: release the lock and arbitrate normally now.
               gnt     = norm_gnt;
               state_d = IDLE;
               cnt_d   = 8'd0;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = 8'd0;
         end
      endcase

      if (|gnt[SRC_TR:SRC_ALU]) begin
         block_d = 1'b0;
      end

      if (rst) begin
         gnt = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= 8'd0;
         block_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         block_q <= block_d;
      end
   end

   // One-hot AND-OR select of the winner's address and data.
   logic [AW-1:0] sel_addr;
   logic [DW-1:0] sel_data;

   always_comb begin
      sel_addr = '0;
      sel_data = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (gnt[i]) begin
            sel_addr = sel_addr | addr_arr[i];
            sel_data = sel_data | data_arr[i];
         end
      end
   end

   logic          wr_en_q;
   logic [AW-1:0] wr_addr_q;
   logic [DW-1:0] wr_data_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
      end else begin
         wr_en_q <= |gnt;
         if (|gnt) begin
            wr_addr_q <= sel_addr;
            wr_data_q <= sel_data;
         end
      end
   end

   assign wr_en   = wr_en_q;
   assign wr_addr = wr_addr_q;
   assign wr_data = wr_data_q;
   assign locked  = (state_q == LOCK);

endmodule

// File: doc/reg_wb_arbiter.md
Name: reg_wb_arbiter

Overview:
Write-back scheduler for the single register-file write port. Five producers compete for the port: ALU, MOV, load (DM), accumulator transfer (TR) and the multi-cycle Fibonacci unit (FIB). The block arbitrates them with fixed priority, starvation ageing and a FIB burst lock. It returns a per-source grant and drives a registered write strobe, address and data to the register file, replacing ad-hoc flag-based selection.

Parameters:
DW, 16, data width of register-file write data.
AW, 3, register address width.
STARVE_LIM, 4, consecutive denied cycles before a requester is promoted to top priority; range 1..15.
LOCK_MAX, 8, maximum FIB writes per burst lock; range 1..255.

Ports:
clk  in  1  system clock; all state changes on rising edge.
rst  in  1  synchronous, active-high reset.
req  in  5  request per source; bit0 ALU, bit1 MOV, bit2 L, bit3 TR, bit4 FIB.
addr_alu, addr_mov, addr_l, addr_tr, addr_fib  in  AW each  destination register per source.
data_alu, data_mov, data_l, data_tr, data_fib  in  DW each  write data per source.
fib_burst  in  1  FIB requests burst lock; sampled only when FIB is granted.
gnt  out  5  one-hot grant, combinational, same cycle as the winning req.
wr_en  out  1  register-file write enable, registered.
wr_addr  out  AW  registered write address.
wr_data  out  DW  registered write data.
locked  out  1  high while in LOCK state.

Behaviour:
- Handshake: a source holds req high with stable addr and data until it sees gnt high in the same cycle. The transfer completes on that edge. Deasserting req before grant is legal and clears that source's age counter.
- gnt is at most one-hot and is zero when req is zero. A gnt bit is never high without its req bit.
- Latency: a grant in cycle N produces wr_en=1 in cycle N+1, with the granted addr and data captured at edge N. With no grant in cycle N, wr_en=0 in cycle N+1; wr_addr and wr_data hold their previous values.
- Priority: ALU > MOV > L > TR > FIB (lowest index wins).
- Ageing: each source has a counter age[i] of 4 bits.
  - Counter increments, saturating at STARVE_LIM, when req[i]=1 and gnt[i]=0.
  - Counter clears on grant or when req[i]=0.
  - A source with age[i]==STARVE_LIM is "starved". Starved sources outrank all non-starved sources; among starved sources, fixed priority applies.
- FSM states: IDLE, LOCK.
  - IDLE: normal arbitration. FIB granted with fib_burst=1 -> LOCK, with lock counter cnt=1.
  - LOCK: locked=1.
    - FIB requesting: gnt=FIB only, cnt increments, and ageing of other sources continues.
    - Exit to IDLE at the edge where FIB is granted with fib_burst=0, or cnt reaches LOCK_MAX. That final grant is the last locked write.
    - req[4]=0 while in LOCK: exit to IDLE in the same edge; normal arbitration resumes in that cycle.
  - After a LOCK_MAX exit, the FIB age counter is cleared. FIB cannot re-enter LOCK until at least one other pending source has been granted; if none are pending, re-lock is allowed.
- Reset: state=IDLE, wr_en=0, wr_addr=0, wr_data=0, locked=0, all age counters and cnt=0. Grants are suppressed (gnt=0) during any cycle with rst=1. Reset during LOCK drops the burst; requesters keep req and are re-arbitrated after reset.
- Simultaneous events: all five requesting in IDLE with no starvation grants ALU. A starved FIB beats a fresh ALU request. Same-address back-to-back writes are not merged; the later write wins in the register file.

Decomposition:
- Shared package: source index constants (SRC_ALU=0..SRC_FIB=4), NUM_SRC=5, FSM state encoding (IDLE, LOCK), default DW and AW.
- One sub-module: prio_pick. It is a combinational fixed-priority one-hot picker over a 5-bit vector, instantiated twice (starved mask, full mask) and combined by "starved non-empty ? starved pick : full pick".

Test Plan:
1. req=5'b11111 continuously, fib_burst=0, STARVE_LIM=4 -> ALU granted for 4 cycles. Cycle 5 grants MOV (starved, lowest index), cycle 6 grants L, and so on. Every source receives a grant within 5×STARVE_LIM cycles; wr_en rises one cycle after each grant.
2. Single ALU request, addr_alu=3, data_alu=16'h1234 at cycle N -> gnt=5'b00001 in N; wr_en=1, wr_addr=3, wr_data=16'h1234 in N+1; wr_en=0 in N+2.
3. FIB alone with fib_burst=1 and ALU requesting concurrently, LOCK_MAX=8 -> exactly 8 consecutive FIB grants, locked=1 throughout, then ALU granted. FIB does not re-lock until ALU is served.
4. LOCK entered, fib_burst drops after the 3rd grant -> 3 FIB writes, then IDLE; a pending MOV is granted on the next cycle.
5. rst asserted during LOCK with wr_en=1 -> next cycle wr_en=0, locked=0, gnt=0 while rst=1. After release, MOV pending is granted first cycle.
6. Requester drops req after 3 denied cycles, then reasserts -> age restarts at 0; no premature starvation promotion.
